rom_scan_streamer: RTL and testbench
====================================

// Module: rom_scan_streamer
// PURPOSE
//  Sequences block-ROM reads over addresses 0..NUM_WORDS-1 and delivers each word as
//  a valid/ready stream beat, with the last word tagged. Sits between the single-port
//  block ROM and the downstream max-search/accumulate stage. Absorbs the ROM's
//  READ_LAT-cycle read latency and downstream backpressure without dropping or
//  duplicating words. One scan runs per start pulse.
// PARAMETERS
//  ADDR_W     4   ROM address width
//  DATA_W     4   ROM data width
//  NUM_WORDS  10  words per scan, 1..2**ADDR_W
//  READ_LAT   1   ROM clock-to-dout latency in cycles, 1 or 2
// PORTS
//  clk       in   1       single clock, rising edge
//  rst_n     in   1       asynchronous, active-low reset
//  start     in   1       1-cycle pulse; begins a scan when idle
//  busy      out  1       high from the accepted start until done
//  done      out  1       1-cycle pulse after the last beat is accepted
//  rom_en    out  1       ROM read enable
//  rom_addr  out  ADDR_W  ROM read address
//  rom_dout  in   DATA_W  ROM data, valid READ_LAT cycles after rom_en
//  m_valid   out  1       stream beat valid
//  m_data    out  DATA_W  stream beat data
//  m_last    out  1       beat carries address NUM_WORDS-1
//  m_ready   in   1       downstream accepts the beat when high with m_valid
// BEHAVIOUR
//  Reset values
//   - busy, done, rom_en, m_valid, m_last = 0
//   - rom_addr = 0, m_data = 0
//   - FSM in IDLE, buffer empty, in-flight count = 0
//  FSM states
//   - IDLE:  start=1 -> ISSUE; issue pointer cleared to 0; busy rises next cycle.
//   - ISSUE: drives rom_en=1 and rom_addr=ptr when (buffered + in-flight) < READ_LAT+1,
//            then increments ptr. The read with ptr==NUM_WORDS-1 moves the FSM to DRAIN.
//   - DRAIN: rom_en=0. Waits until the buffer is empty and no reads are in flight,
//            then moves to DONE.
//   - DONE:  done=1 for exactly 1 cycle, busy drops the same cycle, then -> IDLE.
//  Read latency handling
//   - A READ_LAT-deep shift register of valid bits tracks in-flight reads.
//   - rom_dout is written into a (READ_LAT+1)-entry FIFO when the shift register's
//     last valid bit is set.
//   - The credit rule guarantees the FIFO never overflows, so no skid is lost.
//  Stream rules
//   - m_valid = FIFO not empty; m_data/m_last come from the FIFO head.
//   - A beat pops only on m_valid & m_ready.
//   - While m_valid=1 and m_ready=0, m_data and m_last hold stable.
//   - Beats arrive in address order, exactly NUM_WORDS per scan; exactly one has m_last=1.
//  Latency, m_ready held high, READ_LAT=1
//   - start sampled at edge E0 -> rom_en=1, addr 0 after E0.
//   - m_valid=1 with word 0 after E2.
//   - 1 beat per cycle thereafter; done pulses 1 cycle after the last beat is accepted.
//  Boundaries
//   - start while busy is ignored.
//   - rom_addr never exceeds NUM_WORDS-1; ptr does not wrap within a scan.
//   - NUM_WORDS=1: one beat, with m_last=1.
//   - Simultaneous FIFO push and pop in the same cycle: occupancy is unchanged.
//   - rst_n asserted mid-scan: all state clears immediately; in-flight data is
//     discarded; no done pulse.
//   - After rst_n deasserts, the block stays idle until the next start.
// TESTING
//  1. Reset, start pulse, m_ready=1, ROM[i]=i -> beats 0..9 on consecutive cycles;
//     first m_valid 2 cycles after start; m_last only on beat 9; done 1 cycle later.
//  2. m_ready toggled 1/0 every cycle -> same 10 beats in order, none lost or duplicated;
//     data stable during stalls.
//  3. m_ready=0 for 20 cycles after start -> rom_en stops after READ_LAT+1 reads;
//     m_valid holds word 0; releasing m_ready completes the scan normally.
//  4. start re-pulsed mid-scan -> ignored; exactly 10 beats; a single done pulse.
//  5. rst_n pulled low while beat 4 is pending -> outputs return to reset values
//     asynchronously; a new start yields words 0..9 from address 0.
//  6. READ_LAT=2 and NUM_WORDS=1 builds -> correct ordering and m_last;
//     done follows the single beat.

Source files
------------

// File: rtl/rom_scan_streamer_if.sv
// Bus bundle for rom_scan_streamer: the block-ROM read port plus the output stream.
//
// Handshake semantics (stream side): a beat transfers on every rising clk edge where
// m_valid and m_ready are both high. Once m_valid is raised it stays high, and m_data
// and m_last stay stable, until the beat transfers. m_ready may change freely and
// may depend on m_valid. The ROM side has no handshake: a read is issued on every
// edge where rom_en is high, and rom_dout carries the word READ_LAT cycles later.
interface rom_scan_streamer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_dout;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    // Streamer side: drives ROM reads and the stream beat.
    modport master (
        output rom_en, rom_addr, m_valid, m_data, m_last,
        input  rom_dout, m_ready
    );

    // ROM + downstream consumer side.
    modport slave (
        input  rom_en, rom_addr, m_valid, m_data, m_last,
        output rom_dout, m_ready
    );
endinterface

// File: rtl/rom_scan_streamer.sv
// rom_scan_streamer: reads ROM addresses 0..NUM_WORDS-1 once per start pulse and
// emits each word as a stream beat, tagging the last one. A credit counter limits
// outstanding reads to the FIFO depth so downstream backpressure never loses data.
module rom_scan_streamer #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 4,
    parameter int NUM_WORDS = 10,
    parameter int READ_LAT  = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [1:0]                 dbg_state,
    rom_scan_streamer_if.master        bus
);
    localparam int DEPTH = READ_LAT + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [CW:0]       DEPTH_W   = (CW + 1)'(DEPTH);
    localparam logic [PW-1:0]     PTR_TOP   = PW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [READ_LAT-1:0] fl_valid;
    logic [READ_LAT-1:0] fl_last;
    logic [READ_LAT-1:0] fl_valid_next;
    logic [READ_LAT-1:0] fl_last_next;
    logic [DATA_W-1:0]   mem_data [DEPTH];
    logic                mem_last [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic [CW:0]         in_flight;
    logic [CW:0]         credit_used;
    logic                push;
    logic                pop;
    logic                drained;

    assign dbg_state = state;

    // Stream side is read straight from the FIFO head; m_last is gated so a stale
    // entry can never show a last tag while the FIFO is empty.
    assign bus.m_valid  = (count != '0);
    assign bus.m_data   = mem_data[rd_ptr];
    assign bus.m_last   = bus.m_valid & mem_last[rd_ptr];
    assign bus.rom_addr = ptr;

    assign push = fl_valid[READ_LAT-1];
    assign pop  = bus.m_valid & bus.m_ready;

    // Credit check and next-cycle bookkeeping. A pop happening this cycle frees its
    // slot in time for the new read, which is what allows one beat per cycle.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            in_flight = in_flight + (CW + 1)'(fl_valid[i]);
        end
        credit_used = (CW + 1)'(count) - (CW + 1)'(pop) + in_flight;
        bus.rom_en  = (state == S_ISSUE) && (credit_used < DEPTH_W);

        fl_valid_next    = '0;
        fl_last_next     = '0;
        fl_valid_next[0] = bus.rom_en;
        fl_last_next[0]  = (ptr == LAST_ADDR);
        for (int i = 1; i < READ_LAT; i++) begin
            fl_valid_next[i] = fl_valid[i-1];
            fl_last_next[i]  = fl_last[i-1];
        end

        count_next = count + CW'(push) - CW'(pop);
        drained    = (count_next == '0) && (fl_valid_next == '0);
    end

    // Scan sequencer: issue pointer, busy and the single-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_ISSUE;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (bus.rom_en) begin
                        if (ptr == LAST_ADDR) begin
                            state <= S_DRAIN;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // In-flight tracker: one valid/last bit per cycle of ROM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_valid <= '0;
            fl_last  <= '0;
        end else begin
            fl_valid <= fl_valid_next;
            fl_last  <= fl_last_next;
        end
    end

    // Output FIFO: captures ROM words as they land, releases them on accepted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= bus.rom_dout;
                mem_last[wr_ptr] <= fl_last[READ_LAT-1];
                wr_ptr           <= (wr_ptr == PTR_TOP) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_TOP) ? '0 : rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end
endmodule

// File: tb/tb_rom_scan_streamer.sv
// Bench for rom_scan_streamer: three instances (READ_LAT=1/NUM_WORDS=10,
// READ_LAT=2/NUM_WORDS=10, READ_LAT=1/NUM_WORDS=1) each fed by a small ROM model.
module tb_rom_scan_streamer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic ready_a = 1'b1, ready_b = 1'b1, ready_c = 1'b1;
    logic busy_a, busy_b, busy_c;
    logic done_a, done_b, done_c;
    logic [1:0] dbg_a, dbg_b, dbg_c;
    logic [3:0] rom_a_q = '0, rom_b_s1 = '0, rom_b_s2 = '0, rom_c_q = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations gathered by run_scan.
    logic [3:0] beat_data_q[$];
    logic       beat_last_q[$];
    int         beat_cyc_q[$];
    int         done_cnt, done_cyc, reads_total, reads_stalled, stall_viol, max_addr, first_valid;
    logic       busy_c0, en_c0, busy_at_done, valid_hold;
    logic [3:0] addr_c0, data_hold;

    // Clock and reset
    always #5 clk = ~clk;

    rom_scan_streamer_if #(.ADDR_W(4), .DATA_W(4)) bus_a ();
    rom_scan_streamer_if #(.ADDR_W(4), .DATA_W(4)) bus_b ();
    rom_scan_streamer_if #(.ADDR_W(4), .DATA_W(4)) bus_c ();

    rom_scan_streamer #(.ADDR_W(4), .DATA_W(4), .NUM_WORDS(10), .READ_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .dbg_state(dbg_a), .bus(bus_a.master));
    rom_scan_streamer #(.ADDR_W(4), .DATA_W(4), .NUM_WORDS(10), .READ_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .dbg_state(dbg_b), .bus(bus_b.master));
    rom_scan_streamer #(.ADDR_W(4), .DATA_W(4), .NUM_WORDS(1), .READ_LAT(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
        .dbg_state(dbg_c), .bus(bus_c.master));

    // ROM models: A holds ROM[i]=i, B holds ROM[i]=15-i with 2-cycle latency, C holds 0xA.
    assign bus_a.m_ready  = ready_a;
    assign bus_b.m_ready  = ready_b;
    assign bus_c.m_ready  = ready_c;
    assign bus_a.rom_dout = rom_a_q;
    assign bus_b.rom_dout = rom_b_s2;
    assign bus_c.rom_dout = rom_c_q;

    always @(posedge clk) if (bus_a.rom_en) rom_a_q <= bus_a.rom_addr;
    always @(posedge clk) begin
        if (bus_b.rom_en) rom_b_s1 <= 4'hF - bus_b.rom_addr;
        rom_b_s2 <= rom_b_s1;
    end
    always @(posedge clk) if (bus_c.rom_en) rom_c_q <= 4'hA ^ bus_c.rom_addr;

    // Driver: start and m_ready for one instance.
    task automatic drive(input int inst, input logic st, input logic rd);
        case (inst)
            0: begin start_a = st; ready_a = rd; end
            1: begin start_b = st; ready_b = rd; end
            default: begin start_c = st; ready_c = rd; end
        endcase
    endtask

    // Driver + monitor: pulses start, then per cycle drives m_ready (mode 0 always 1,
    // mode 1 toggling, mode 2 low for 'hold' cycles), optionally re-pulses start at
    // cycle 'restart', and records beats. Cycle c is the negedge after the c-th edge
    // following the one that sampled start.
    task automatic run_scan(input int inst, input int mode, input int hold, input int restart);
        logic s_valid, s_last, s_en, s_busy, s_done, rdy, p_stall, p_last;
        logic [3:0] s_data, s_addr, p_data;
        int c;
        bit fin;
        beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
        done_cnt = 0; done_cyc = -1; reads_total = 0; reads_stalled = 0; stall_viol = 0;
        max_addr = -1; first_valid = -1; valid_hold = 1'b0; data_hold = '0;
        busy_c0 = 1'b0; en_c0 = 1'b0; addr_c0 = 'x; busy_at_done = 1'bx;
        p_stall = 1'b0; p_last = 1'b0; p_data = '0;
        @(negedge clk);
        drive(inst, 1'b1, 1'b1);
        c = 0;
        fin = 0;
        while (!fin && c < 300) begin
            @(negedge clk);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : (c >= hold);
            drive(inst, (c == restart), rdy);
            #1;
            case (inst)
                0: begin s_valid = bus_a.m_valid; s_data = bus_a.m_data; s_last = bus_a.m_last;
                         s_en = bus_a.rom_en; s_addr = bus_a.rom_addr; s_busy = busy_a; s_done = done_a; end
                1: begin s_valid = bus_b.m_valid; s_data = bus_b.m_data; s_last = bus_b.m_last;
                         s_en = bus_b.rom_en; s_addr = bus_b.rom_addr; s_busy = busy_b; s_done = done_b; end
                default: begin s_valid = bus_c.m_valid; s_data = bus_c.m_data; s_last = bus_c.m_last;
                         s_en = bus_c.rom_en; s_addr = bus_c.rom_addr; s_busy = busy_c; s_done = done_c; end
            endcase
            if (c == 0) begin busy_c0 = s_busy; en_c0 = s_en; addr_c0 = s_addr; end
            if (mode == 2 && c == hold - 1) begin valid_hold = s_valid; data_hold = s_data; end
            if (s_en === 1'b1) begin
                reads_total++;
                if (!rdy) reads_stalled++;
                if (int'(s_addr) > max_addr) max_addr = int'(s_addr);
            end
            if (p_stall && (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last)) stall_viol++;
            if (s_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (s_valid === 1'b1 && rdy) begin
                beat_data_q.push_back(s_data);
                beat_last_q.push_back(s_last);
                beat_cyc_q.push_back(c);
            end
            p_stall = (s_valid === 1'b1) && !rdy;
            p_data  = s_data;
            p_last  = s_last;
            if (s_done === 1'b1) begin done_cnt++; done_cyc = c; busy_at_done = s_busy; end
            if (done_cnt > 0 && c >= done_cyc + 3) fin = 1;
            c++;
        end
        drive(inst, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy_a, done_a, bus_a.rom_en, bus_a.m_valid, bus_a.m_last} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {busy_a, done_a, bus_a.rom_en, bus_a.m_valid, bus_a.m_last});
        end
        n_tests++;
        if (bus_a.rom_addr !== 4'd0 || bus_a.m_data !== 4'd0 || dbg_a !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_values: addr=%0h data=%0h state=%0d expected 0/0/0",
                     bus_a.rom_addr, bus_a.m_data, dbg_a);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b0 || bus_a.rom_en !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy_a=%b rom_en=%b busy_b=%b busy_c=%b expected all 0",
                     busy_a, bus_a.rom_en, busy_b, busy_c);
        end
    endtask

    task automatic test_stream_full_rate();
        run_scan(0, 0, 0, -1);
        n_tests++;
        if (busy_c0 !== 1'b1 || en_c0 !== 1'b1 || addr_c0 !== 4'd0) begin
            n_fail++;
            $display("FAIL first_issue: busy=%b rom_en=%b addr=%0h expected 1/1/0", busy_c0, en_c0, addr_c0);
        end
        n_tests++;
        if (first_valid !== 2) begin
            n_fail++;
            $display("FAIL first_valid_cycle: got %0d expected 2", first_valid);
        end
        n_tests++;
        if (beat_data_q.size() !== 10) begin
            n_fail++;
            $display("FAIL full_rate_count: got %0d expected 10", beat_data_q.size());
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (k >= beat_data_q.size() || beat_data_q[k] !== 4'(k) || beat_last_q[k] !== (k == 9)
                || beat_cyc_q[k] !== 2 + k) begin
                n_fail++;
                $display("FAIL full_rate_beat%0d: got data/last/cycle %0h/%b/%0d expected %0h/%b/%0d",
                         k, (k < beat_data_q.size()) ? beat_data_q[k] : 4'hx,
                         (k < beat_data_q.size()) ? beat_last_q[k] : 1'bx,
                         (k < beat_data_q.size()) ? beat_cyc_q[k] : -1, 4'(k), (k == 9), 2 + k);
            end
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 12 || busy_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_rate_done: count=%0d cycle=%0d busy=%b expected 1/12/0",
                     done_cnt, done_cyc, busy_at_done);
        end
        n_tests++;
        if (reads_total !== 10 || max_addr !== 9) begin
            n_fail++;
            $display("FAIL full_rate_reads: reads=%0d max_addr=%0d expected 10/9", reads_total, max_addr);
        end
    endtask

    task automatic test_toggle_ready();
        int n_last;
        run_scan(0, 1, 0, -1);
        n_tests++;
        if (beat_data_q.size() !== 10) begin
            n_fail++;
            $display("FAIL toggle_count: got %0d expected 10", beat_data_q.size());
        end
        n_last = 0;
        for (int k = 0; k < beat_last_q.size(); k++) if (beat_last_q[k] === 1'b1) n_last++;
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (k >= beat_data_q.size() || beat_data_q[k] !== 4'(k)) begin
                n_fail++;
                $display("FAIL toggle_beat%0d: got %0h expected %0h", k,
                         (k < beat_data_q.size()) ? beat_data_q[k] : 4'hx, 4'(k));
            end
        end
        n_tests++;
        if (n_last !== 1 || stall_viol !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL toggle_misc: lasts=%0d stall_changes=%0d dones=%0d expected 1/0/1",
                     n_last, stall_viol, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        run_scan(0, 2, 20, -1);
        n_tests++;
        if (reads_stalled !== 2) begin
            n_fail++;
            $display("FAIL bp_reads_while_stalled: got %0d expected 2", reads_stalled);
        end
        n_tests++;
        if (valid_hold !== 1'b1 || data_hold !== 4'd0 || stall_viol !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: valid=%b data=%0h stall_changes=%0d expected 1/0/0",
                     valid_hold, data_hold, stall_viol);
        end
        n_tests++;
        if (beat_data_q.size() !== 10 || beat_data_q[9] !== 4'd9 || beat_last_q[9] !== 1'b1
            || reads_total !== 10 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL bp_complete: beats=%0d reads=%0d dones=%0d expected 10/10/1",
                     beat_data_q.size(), reads_total, done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        bit ok;
        run_scan(0, 0, 0, 5);
        ok = (beat_data_q.size() == 10);
        for (int k = 0; k < beat_data_q.size(); k++) if (beat_data_q[k] !== 4'(k)) ok = 0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL restart_beats: got %0d beats, expected 10 in order 0..9", beat_data_q.size());
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 12) begin
            n_fail++;
            $display("FAIL restart_done: count=%0d cycle=%0d expected 1/12", done_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit found;
        bit saw_done;
        found = 0;
        saw_done = 0;
        @(negedge clk);
        start_a = 1'b1;
        ready_a = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            start_a = 1'b0;
            #1;
            if (bus_a.m_valid === 1'b1 && bus_a.m_data === 4'd4) found = 1;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_reset_reach_beat4: got no pending beat 4 expected one within 20 cycles");
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy_a, done_a, bus_a.rom_en, bus_a.m_valid, bus_a.m_last} !== 5'b0
            || bus_a.rom_addr !== 4'd0 || bus_a.m_data !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: flags=%b addr=%0h data=%0h expected 00000/0/0",
                     {busy_a, done_a, bus_a.rom_en, bus_a.m_valid, bus_a.m_last},
                     bus_a.rom_addr, bus_a.m_data);
        end
        repeat (3) begin
            @(negedge clk);
            if (done_a === 1'b1) saw_done = 1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1 || bus_a.m_valid === 1'b1) saw_done = 1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL mid_reset_quiet: got activity (done/busy/m_valid) after reset expected none");
        end
        run_scan(0, 0, 0, -1);
        n_tests++;
        if (beat_data_q.size() !== 10 || beat_data_q[0] !== 4'd0 || beat_data_q[9] !== 4'd9
            || first_valid !== 2 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL mid_reset_rescan: beats=%0d first_valid=%0d dones=%0d expected 10/2/1",
                     beat_data_q.size(), first_valid, done_cnt);
        end
    endtask

    task automatic test_read_lat2();
        run_scan(1, 0, 0, -1);
        n_tests++;
        if (first_valid !== 3 || beat_data_q.size() !== 10) begin
            n_fail++;
            $display("FAIL lat2_start: first_valid=%0d beats=%0d expected 3/10", first_valid, beat_data_q.size());
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (k >= beat_data_q.size() || beat_data_q[k] !== 4'(15 - k) || beat_last_q[k] !== (k == 9)
                || beat_cyc_q[k] !== 3 + k) begin
                n_fail++;
                $display("FAIL lat2_beat%0d: got data/cycle %0h/%0d expected %0h/%0d", k,
                         (k < beat_data_q.size()) ? beat_data_q[k] : 4'hx,
                         (k < beat_data_q.size()) ? beat_cyc_q[k] : -1, 4'(15 - k), 3 + k);
            end
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 13) begin
            n_fail++;
            $display("FAIL lat2_done: count=%0d cycle=%0d expected 1/13", done_cnt, done_cyc);
        end
        run_scan(1, 2, 10, -1);
        n_tests++;
        if (reads_stalled !== 3 || valid_hold !== 1'b1 || data_hold !== 4'hF) begin
            n_fail++;
            $display("FAIL lat2_backpressure: reads=%0d valid=%b data=%0h expected 3/1/f",
                     reads_stalled, valid_hold, data_hold);
        end
        n_tests++;
        if (beat_data_q.size() !== 10 || beat_data_q[9] !== 4'h6 || stall_viol !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL lat2_bp_complete: beats=%0d stall_changes=%0d dones=%0d expected 10/0/1",
                     beat_data_q.size(), stall_viol, done_cnt);
        end
    endtask

    task automatic test_single_word();
        run_scan(2, 0, 0, -1);
        n_tests++;
        if (beat_data_q.size() !== 1 || beat_data_q[0] !== 4'hA || beat_last_q[0] !== 1'b1
            || first_valid !== 2) begin
            n_fail++;
            $display("FAIL single_beat: beats=%0d data=%0h first_valid=%0d expected 1/a/2 with last",
                     beat_data_q.size(), beat_data_q[0], first_valid);
        end
        n_tests++;
        if (done_cnt !== 1 || done_cyc !== 3 || reads_total !== 1 || max_addr !== 0) begin
            n_fail++;
            $display("FAIL single_done: dones=%0d cycle=%0d reads=%0d max_addr=%0d expected 1/3/1/0",
                     done_cnt, done_cyc, reads_total, max_addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream_full_rate();
        test_toggle_ready();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_scan();
        test_read_lat2();
        test_single_word();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
